// File: rtl/hicore_icb_splt_if.sv
// ICB splitter bus bundle: upstream command/response plus SPLT_NUM flattened downstream ports.
interface hicore_icb_splt_if #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int SPLT_NUM = 2
);
  logic                     i_icb_cmd_valid;
  logic                     i_icb_cmd_ready;
  logic                     i_icb_cmd_read;
  logic [AW-1:0]            i_icb_cmd_addr;
  logic [DW-1:0]            i_icb_cmd_wdata;
  logic [DW/8-1:0]          i_icb_cmd_wmask;
  logic                     i_icb_rsp_valid;
  logic                     i_icb_rsp_ready;
  logic                     i_icb_rsp_err;
  logic [DW-1:0]            i_icb_rsp_rdata;

  logic [SPLT_NUM-1:0]      o_bus_icb_cmd_valid;
  logic [SPLT_NUM-1:0]      o_bus_icb_cmd_ready;
  logic [SPLT_NUM-1:0]      o_bus_icb_cmd_read;
  logic [SPLT_NUM*AW-1:0]   o_bus_icb_cmd_addr;
  logic [SPLT_NUM*DW-1:0]   o_bus_icb_cmd_wdata;
  logic [SPLT_NUM*DW/8-1:0] o_bus_icb_cmd_wmask;
  logic [SPLT_NUM-1:0]      o_bus_icb_rsp_valid;
  logic [SPLT_NUM-1:0]      o_bus_icb_rsp_ready;
  logic [SPLT_NUM-1:0]      o_bus_icb_rsp_err;
  logic [SPLT_NUM*DW-1:0]   o_bus_icb_rsp_rdata;

  // splitter side
  modport slave (
    input  i_icb_cmd_valid, i_icb_cmd_read, i_icb_cmd_addr, i_icb_cmd_wdata, i_icb_cmd_wmask,
    output i_icb_cmd_ready,
    output i_icb_rsp_valid, i_icb_rsp_err, i_icb_rsp_rdata,
    input  i_icb_rsp_ready,
    output o_bus_icb_cmd_valid, o_bus_icb_cmd_read, o_bus_icb_cmd_addr,
    output o_bus_icb_cmd_wdata, o_bus_icb_cmd_wmask,
    input  o_bus_icb_cmd_ready,
    input  o_bus_icb_rsp_valid, o_bus_icb_rsp_err, o_bus_icb_rsp_rdata,
    output o_bus_icb_rsp_ready
  );

  // upstream master + downstream targets
  modport master (
    output i_icb_cmd_valid, i_icb_cmd_read, i_icb_cmd_addr, i_icb_cmd_wdata, i_icb_cmd_wmask,
    input  i_icb_cmd_ready,
    input  i_icb_rsp_valid, i_icb_rsp_err, i_icb_rsp_rdata,
    output i_icb_rsp_ready,
    input  o_bus_icb_cmd_valid, o_bus_icb_cmd_read, o_bus_icb_cmd_addr,
    input  o_bus_icb_cmd_wdata, o_bus_icb_cmd_wmask,
    output o_bus_icb_cmd_ready,
    output o_bus_icb_rsp_valid, o_bus_icb_rsp_err, o_bus_icb_rsp_rdata,
    input  o_bus_icb_rsp_ready
  );
endinterface

// File: rtl/hicore_icb_splt.sv
// ICB 1-to-SPLT_NUM address splitter with an in-order response id FIFO.
// Define HICORE_ICB_SPLT_ERR_EN to answer unmatched addresses from an internal error port.

module hicore_icb_splt_hit #(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] mask,
  output logic          hit
);
  assign hit = ((addr & mask) == (base & mask));
endmodule

module hicore_icb_splt #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int SPLT_NUM      = 2,
  parameter int SPLT_PTR_W    = 2,
  parameter int FIFO_OUTS_NUM = 2,
  parameter logic [SPLT_NUM*AW-1:0] SPLT_BASE = {32'h1000_0000, 32'h8000_0000},
  parameter logic [SPLT_NUM*AW-1:0] SPLT_MASK = {32'hF000_0000, 32'hF000_0000}
) (
  input  logic             clk,
  input  logic             rst_n,
  hicore_icb_splt_if.slave bus,
  output logic             o_splt_busy
);
  localparam int PW = (FIFO_OUTS_NUM > 1) ? $clog2(FIFO_OUTS_NUM) : 1;
  localparam int CW = $clog2(FIFO_OUTS_NUM + 1);
`ifdef HICORE_ICB_SPLT_ERR_EN
  localparam logic [SPLT_PTR_W-1:0] MISS_ID = SPLT_PTR_W'(SPLT_NUM);
`else
  localparam logic [SPLT_PTR_W-1:0] MISS_ID = SPLT_PTR_W'(SPLT_NUM-1);
`endif
  localparam logic [SPLT_NUM-1:0][AW-1:0] BASE_A = SPLT_BASE;
  localparam logic [SPLT_NUM-1:0][AW-1:0] MASK_A = SPLT_MASK;

  logic [SPLT_NUM-1:0]          hit;
  logic [SPLT_PTR_W-1:0]        sel;
  logic [SPLT_NUM-1:0]          cmd_vld;
  logic                         port_rdy;
  logic                         full, empty, push, pop;
  logic [PW-1:0]                wptr, rptr;
  logic [CW-1:0]                cnt;
  logic [SPLT_PTR_W-1:0]        mem [0:(1<<PW)-1];
  logic [SPLT_PTR_W-1:0]        head;
  logic [SPLT_NUM-1:0][DW-1:0]  rdata_a;
  logic                         rsp_vld, rsp_err;
  logic [DW-1:0]                rsp_rdata;
  logic [SPLT_NUM-1:0]          rsp_rdy;

  for (genvar k = 0; k < SPLT_NUM; k++) begin : g_dec
    hicore_icb_splt_hit #(.AW(AW)) u_hit (
      .addr (bus.i_icb_cmd_addr),
      .base (BASE_A[k]),
      .mask (MASK_A[k]),
      .hit  (hit[k])
    );
  end

  // scan high-to-low so the lowest hitting index wins
  always_comb begin
    sel = MISS_ID;
    for (int k = SPLT_NUM-1; k >= 0; k--)
      if (hit[k]) sel = SPLT_PTR_W'(k);
  end

  assign full  = (cnt == CW'(FIFO_OUTS_NUM));
  assign empty = (cnt == '0);

  always_comb begin
    cmd_vld  = '0;
    port_rdy = 1'b0;
    for (int k = 0; k < SPLT_NUM; k++)
      if (sel == SPLT_PTR_W'(k)) begin
        cmd_vld[k] = bus.i_icb_cmd_valid & ~full;
        port_rdy   = bus.o_bus_icb_cmd_ready[k];
      end
`ifdef HICORE_ICB_SPLT_ERR_EN
    if (sel == MISS_ID) port_rdy = 1'b1;
`endif
  end

  assign bus.i_icb_cmd_ready     = port_rdy & ~full;
  assign bus.o_bus_icb_cmd_valid = cmd_vld;
  assign bus.o_bus_icb_cmd_read  = {SPLT_NUM{bus.i_icb_cmd_read}};
  assign bus.o_bus_icb_cmd_addr  = {SPLT_NUM{bus.i_icb_cmd_addr}};
  assign bus.o_bus_icb_cmd_wdata = {SPLT_NUM{bus.i_icb_cmd_wdata}};
  assign bus.o_bus_icb_cmd_wmask = {SPLT_NUM{bus.i_icb_cmd_wmask}};

  assign push = bus.i_icb_cmd_valid & bus.i_icb_cmd_ready;
  assign pop  = rsp_vld & bus.i_icb_rsp_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_OUTS_NUM-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head    = mem[rptr];
  assign rdata_a = bus.o_bus_icb_rsp_rdata;

  // responses only ever come from the port at the FIFO head
  always_comb begin
    rsp_vld   = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    rsp_rdy   = '0;
    if (!empty) begin
      for (int k = 0; k < SPLT_NUM; k++)
        if (head == SPLT_PTR_W'(k)) begin
          rsp_vld    = bus.o_bus_icb_rsp_valid[k];
          rsp_err    = bus.o_bus_icb_rsp_err[k];
          rsp_rdata  = rdata_a[k];
          rsp_rdy[k] = bus.i_icb_rsp_ready;
        end
`ifdef HICORE_ICB_SPLT_ERR_EN
      if (head == MISS_ID) begin
        rsp_vld = 1'b1;
        rsp_err = 1'b1;
      end
`endif
    end
  end

  assign bus.i_icb_rsp_valid     = rsp_vld;
  assign bus.i_icb_rsp_err       = rsp_err;
  assign bus.i_icb_rsp_rdata     = rsp_rdata;
  assign bus.o_bus_icb_rsp_ready = rsp_rdy;
  assign o_splt_busy             = ~empty;
endmodule
